// File: rtl/mvb_rr_arbiter.sv
// mvb_rr_arbiter: round-robin merge of PORTS MVB input streams onto one
// registered MVB output with one cycle of latency and full backpressure.
// tx_port carries the index of the source port of the current output word.
// Optional feature: define MVB_RR_ARB_BURST_EN to let a port keep the grant
// for up to BURST_LEN consecutive words; otherwise one word per grant.

module mvb_rr_arbiter #(
  parameter int PORTS      = 4,
  parameter int ITEMS      = 4,
  parameter int ITEM_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [PORTS*ITEMS*ITEM_WIDTH-1:0]            rx_data,
  input  logic [PORTS*ITEMS-1:0]                       rx_vld,
  input  logic [PORTS-1:0]                             rx_src_rdy,
  output logic [PORTS-1:0]                             rx_dst_rdy,
  output logic [ITEMS*ITEM_WIDTH-1:0]                  tx_data,
  output logic [ITEMS-1:0]                             tx_vld,
  output logic                                         tx_src_rdy,
  input  logic                                         tx_dst_rdy,
  output logic [((PORTS > 1) ? $clog2(PORTS) : 1)-1:0] tx_port
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int DW = ITEMS * ITEM_WIDTH;

  // With last at the highest index, the search starts at port 0 after reset.
  localparam logic [PW-1:0] LAST_RST = PW'(PORTS - 1);

  // Reject configurations the arbiter cannot implement.
  if (PORTS < 2 || BURST_LEN < 1) begin : g_bad_cfg
    $error("mvb_rr_arbiter: PORTS must be >= 2 and BURST_LEN must be >= 1");
  end

  logic          out_full;
  logic          can_load;
  logic [PW-1:0] last;
  logic [PW-1:0] rr_grant;
  logic          rr_found;
  logic          stick;
  logic [PW-1:0] grant;
  logic          grant_vld;
  logic          xfer;
  logic [DW-1:0]    sel_data;
  logic [ITEMS-1:0] sel_vld;

  // The output register is the only storage; it can take a new word when it
  // is empty or when its current word leaves at this edge.
  assign out_full = tx_src_rdy;
  assign can_load = !out_full || tx_dst_rdy;

  // Round-robin search: first requesting port after last, wrapping around.
  // The loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // otherwise a path that skips the assignment infers a latch.
    rr_grant = '0;
    rr_found = 1'b0;
    for (int off = PORTS; off >= 1; off--) begin
      if (rx_src_rdy[PW'((int'(last) + off) % PORTS)]) begin
        rr_grant = PW'((int'(last) + off) % PORTS);
        rr_found = 1'b1;
      end
    end
  end

`ifdef MVB_RR_ARB_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);

  logic [BW-1:0] bcnt;

  // A running burst (bcnt != 0) keeps the grant on the last port while it
  // still requests and has not used up its BURST_LEN words.
  assign stick = (bcnt != '0) && (bcnt < BW'(BURST_LEN)) && rx_src_rdy[last];

  // Burst length counter: counts consecutive words taken from one port.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt <= '0;
    end else if (xfer) begin
      bcnt <= stick ? bcnt + BW'(1) : BW'(1);
    end else begin
      bcnt <= '0;
    end
  end
`else
  // Pure round robin: the grant always advances after each word.
  assign stick = 1'b0;
`endif

  assign grant     = stick ? last : rr_grant;
  assign grant_vld = stick || rr_found;
  assign xfer      = can_load && grant_vld && !reset;

  // One-hot accept towards the granted producer; all zero during a stall.
  always_comb begin
    rx_dst_rdy = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (xfer && (grant == PW'(p))) begin
        rx_dst_rdy[p] = 1'b1;
      end
    end
  end

  // Select the granted port's word and item valid flags.
  always_comb begin
    sel_data = '0;
    sel_vld  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (grant == PW'(p)) begin
        sel_data = rx_data[p*DW +: DW];
        sel_vld  = rx_vld[p*ITEMS +: ITEMS];
      end
    end
  end

  // Output register and round-robin pointer. A word with no valid items is
  // consumed and advances the pointer but leaves the output empty.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the data register is reset too, because the output value after
      // reset is part of the interface contract; a word held here is dropped.
      tx_src_rdy <= 1'b0;
      tx_data    <= '0;
      tx_vld     <= '0;
      tx_port    <= '0;
      last       <= LAST_RST;
    end else if (can_load) begin
      if (xfer) begin
        tx_data    <= sel_data;
        tx_vld     <= sel_vld;
        tx_port    <= grant;
        tx_src_rdy <= |sel_vld;
        last       <= grant;
      end else begin
        tx_src_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mvb_rr_arbiter.sv
// Self-checking bench for mvb_rr_arbiter: directed scenarios followed by
// randomized traffic, with a reference model feeding a scoreboard queue and
// a separate monitor that checks every word the DUT hands downstream.
// Define MVB_RR_ARB_BURST_EN for both bench and RTL to model bursts.

module tb_mvb_rr_arbiter;

  localparam int P  = 4;
  localparam int IT = 4;
  localparam int IW = 32;
  localparam int BL = 3;
  localparam int DW = IT * IW;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [P*DW-1:0]   rx_data;
  logic [P*IT-1:0]   rx_vld;
  logic [P-1:0]      rx_src_rdy;
  logic [P-1:0]      rx_dst_rdy;
  logic [DW-1:0]     tx_data;
  logic [IT-1:0]     tx_vld;
  logic              tx_src_rdy;
  logic              tx_dst_rdy;
  logic [PW-1:0]     tx_port;

  mvb_rr_arbiter #(
    .PORTS(P), .ITEMS(IT), .ITEM_WIDTH(IW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_vld(rx_vld), .rx_src_rdy(rx_src_rdy),
    .rx_dst_rdy(rx_dst_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_src_rdy(tx_src_rdy),
    .tx_dst_rdy(tx_dst_rdy), .tx_port(tx_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic [IT-1:0] vld;
  } word_t;

  word_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  // Per-port words the next drive_cycle presents.
  logic [DW-1:0] d_data [P];
  logic [IT-1:0] d_vld  [P];

  // Reference model state, in terms of the arbitration rules.
  int m_last    = P - 1;
  int m_bcnt    = 0;
  bit m_full    = 1'b0;
  bit m_started = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic rand_words(input int zero_odds);
    for (int p = 0; p < P; p++) begin
      d_data[p] = {$urandom, $urandom, $urandom, $urandom};
      d_vld[p]  = IT'($urandom_range(1, (1 << IT) - 1));
      if (zero_odds > 0 && $urandom_range(zero_odds - 1, 0) == 0) d_vld[p] = '0;
    end
  endtask

  // One clock cycle: apply inputs after the edge, check the combinational
  // accept against the model, then advance the model to the next edge.
  task automatic drive_cycle(input logic [P-1:0] src, input logic dst, input logic rst);
    int            g;
    bit            found;
    bit            can_load;
    logic [P-1:0]  exp_rdy;
    word_t         w;
    @(posedge clk);
    #1;
    if (m_started) check("tx_src_rdy", 256'(tx_src_rdy), 256'(m_full));
    reset      = rst;
    rx_src_rdy = src;
    tx_dst_rdy = dst;
    for (int p = 0; p < P; p++) begin
      rx_data[p*DW +: DW] = d_data[p];
      rx_vld[p*IT +: IT]  = d_vld[p];
    end
    #1;
    if (rst) begin
      check("rx_dst_rdy_in_reset", 256'(rx_dst_rdy), 256'(0));
      sb.delete();
      m_full    = 1'b0;
      m_last    = P - 1;
      m_bcnt    = 0;
      m_started = 1'b1;
      return;
    end
    can_load = !m_full || dst;
    found    = 1'b0;
    g        = 0;
`ifdef MVB_RR_ARB_BURST_EN
    if (m_bcnt > 0 && m_bcnt < BL && src[m_last]) begin
      g     = m_last;
      found = 1'b1;
    end
`endif
    for (int k = 1; k <= P && !found; k++) begin
      if (src[(m_last + k) % P]) begin
        g     = (m_last + k) % P;
        found = 1'b1;
      end
    end
    exp_rdy = (can_load && found) ? P'(1 << g) : '0;
    check("rx_dst_rdy", 256'(rx_dst_rdy), 256'(exp_rdy));
    if (can_load && found) begin
      m_bcnt = (g == m_last && m_bcnt > 0 && m_bcnt < BL) ? m_bcnt + 1 : 1;
      m_last = g;
      if (d_vld[g] != '0) begin
        w.port = g;
        w.data = d_data[g];
        w.vld  = d_vld[g];
        sb.push_back(w);
        m_full = 1'b1;
      end else begin
        m_full = 1'b0;
      end
    end else begin
      m_bcnt = 0;
      if (can_load) m_full = 1'b0;
    end
  endtask

  // Monitor: checks each word leaving the DUT against the scoreboard and
  // that a stalled word stays put until it is taken.
  word_t held;
  bit    held_vld = 1'b0;

  always @(negedge clk) begin
    word_t e;
    if (reset !== 1'b0 || tx_src_rdy !== 1'b1) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        check("stall_port", 256'(tx_port), 256'(held.port));
        check("stall_data", 256'(tx_data), 256'(held.data));
        check("stall_vld",  256'(tx_vld),  256'(held.vld));
      end
      if (tx_dst_rdy === 1'b1) begin
        held_vld = 1'b0;
        check("tx_word_expected", 256'(sb.size() != 0), 256'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("tx_port", 256'(tx_port), 256'(e.port));
          check("tx_data", 256'(tx_data), 256'(e.data));
          check("tx_vld",  256'(tx_vld),  256'(e.vld));
        end
      end else begin
        held.port = int'(tx_port);
        held.data = tx_data;
        held.vld  = tx_vld;
        held_vld  = 1'b1;
      end
    end
  end

  initial begin
    reset      = 1'b1;
    rx_src_rdy = '0;
    rx_data    = '0;
    rx_vld     = '0;
    tx_dst_rdy = 1'b0;
    rand_words(0);

    // Reset with requests present: no accepts, registers at reset values.
    drive_cycle('1, 1'b1, 1'b1);
    drive_cycle('1, 1'b1, 1'b1);
    check("reset_tx_src_rdy", 256'(tx_src_rdy), 256'(0));
    check("reset_tx_vld",     256'(tx_vld),     256'(0));
    check("reset_tx_data",    256'(tx_data),    256'(0));
    check("reset_tx_port",    256'(tx_port),    256'(0));

    // All ports requesting, downstream always ready.
    for (int n = 0; n < 12; n++) begin
      rand_words(0);
      drive_cycle('1, 1'b1, 1'b0);
    end

    // Only port 2 requests, eight consecutive words 0x10..0x17.
    for (int n = 0; n < 8; n++) begin
      rand_words(0);
      d_data[2] = {IT{IW'(32'h10 + n)}};
      d_vld[2]  = '1;
      drive_cycle(4'b0100, 1'b1, 1'b0);
    end

    // Downstream stalls for five cycles with everyone requesting, then frees.
    rand_words(0);
    drive_cycle('1, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) drive_cycle('1, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      rand_words(0);
      drive_cycle('1, 1'b1, 1'b0);
    end

    // Empty word on port 1: consumed, not forwarded, advances the pointer.
    drive_cycle('0, 1'b1, 1'b0);
    drive_cycle('0, 1'b1, 1'b0);
    rand_words(0);
    d_vld[1] = '0;
    drive_cycle(4'b0010, 1'b1, 1'b0);
    rand_words(0);
    drive_cycle('1, 1'b1, 1'b0);
    drive_cycle('1, 1'b1, 1'b0);

    // Reset while a word sits stalled in the output register.
    rand_words(0);
    drive_cycle('1, 1'b0, 1'b0);
    drive_cycle('1, 1'b0, 1'b0);
    drive_cycle('1, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      rand_words(0);
      drive_cycle('1, 1'b1, 1'b0);
    end

    // Two ports streaming continuously (burst pattern when enabled).
    for (int n = 0; n < 10; n++) begin
      rand_words(0);
      drive_cycle(4'b0011, 1'b1, 1'b0);
    end

    // Randomized traffic with backpressure and occasional empty words.
    for (int n = 0; n < 500; n++) begin
      rand_words(6);
      drive_cycle(P'($urandom), ($urandom_range(3, 0) != 0), 1'b0);
    end

    // Drain: no requests, downstream ready, everything must have come out.
    for (int n = 0; n < 4; n++) drive_cycle('0, 1'b1, 1'b0);
    check("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mvb_rr_arbiter.md
# mvb_rr_arbiter

Round-robin arbiter that merges PORTS independent MVB input streams onto one registered MVB output. Each granted input word is forwarded whole, with one cycle of latency and full backpressure. It sits in front of shared MVB consumers such as MVB pipes, FIFOs and lookup engines, so that several producers can share one datapath. A TX_PORT sideband identifies the source port of each output word.

## Interface
Parameters:
- PORTS, 4: number of MVB input streams; must be at least 2.
- ITEMS, 4: items per MVB word.
- ITEM_WIDTH, 32: width of one item, in bits.
- BURST_LEN, 4: maximum consecutive words per grant. Used only with MVB_RR_ARB_BURST_EN; must be at least 1.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset, synchronous and active-high.
- RX_DATA  in  PORTS*ITEMS*ITEM_WIDTH  input data; port i occupies slice i.
- RX_VLD  in  PORTS*ITEMS  per-item valid flags, one per item of each port.
- RX_SRC_RDY  in  PORTS  per-port word request.
- RX_DST_RDY  out  PORTS  per-port accept; combinational.
- TX_DATA  out  ITEMS*ITEM_WIDTH  registered output data.
- TX_VLD  out  ITEMS  registered output item valid flags.
- TX_SRC_RDY  out  1  output word present.
- TX_DST_RDY  in  1  downstream accept.
- TX_PORT  out  max(1,clog2(PORTS))  index of the source port for the current TX word.

## Operation
- Output register state:
  - `out_full` equals TX_SRC_RDY.
  - `can_load` = !out_full || TX_DST_RDY.
- Round-robin pointer `last`:
  - Holds the index of the most recently served port.
  - Search order is last+1, last+2, … modulo PORTS.
  - The first port in that order with RX_SRC_RDY=1 is `grant`.
- RX_DST_RDY[i] = can_load && (grant==i) && !RESET. At most one bit is ever set.
- Transfer on port i happens when RX_SRC_RDY[i] && RX_DST_RDY[i]. On transfer:
  - TX_DATA, TX_VLD and TX_PORT load from port i.
  - `last` ← i.
- Empty words: a transferred word whose RX_VLD bits are all zero is consumed and counts as a serve. It is not forwarded; out_full ← 0 unless the register was stalled.
- When can_load=1 and no port requests: out_full ← 0.
- When out_full=1 and TX_DST_RDY=0: all TX outputs hold, and all RX_DST_RDY bits are 0.
- Ports are never starved: any requesting port is served within PORTS transfers. With MVB_RR_ARB_BURST_EN the bound is PORTS*BURST_LEN transfers.
- Reset values:
  - TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, TX_PORT=0.
  - last=PORTS-1, so port 0 has top priority after reset.
  - Burst counter = 0.
  - RX_DST_RDY=0 while RESET=1.
- Reset mid-operation: any word held in the output register is dropped. Words not yet accepted stay with their producers.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on TX in cycle k+1.
- Throughput is one word per cycle when TX_DST_RDY is held at 1.
- Simultaneous events: in a cycle where TX_DST_RDY=1 and a new grant both occur, the old word is sent and the new word is loaded at the same edge, with no bubble.
- Handshake rules:
  - RX_DST_RDY may depend combinationally on RX_SRC_RDY and TX_DST_RDY.
  - TX_SRC_RDY, TX_DATA, TX_VLD and TX_PORT come directly from registers.
  - Once TX_SRC_RDY=1, the TX word stays stable until TX_DST_RDY=1.
- The grant is re-evaluated every cycle. A port that drops RX_SRC_RDY before it is accepted loses its turn, with no penalty.

## Configuration
- Macro: MVB_RR_ARB_BURST_EN.
- When defined, a burst counter `bcnt` of width clog2(BURST_LEN+1) is compiled in:
  - If the last-served port still has RX_SRC_RDY=1 and bcnt < BURST_LEN, grant stays on that port instead of advancing.
  - bcnt increments on each transfer from the same port.
  - bcnt resets to 1 when the grant moves to a different port.
  - bcnt resets to 0 at reset and whenever no transfer occurs.
- When not defined: no counter exists and the arbiter is pure round robin, with one word per grant. This is equivalent to BURST_LEN=1.

## Test plan
- After reset, PORTS=4, all ports requesting, TX_DST_RDY=1 -> TX_PORT sequence 0,1,2,3,0,… with one word per cycle. The first TX word appears 1 cycle after RESET falls.
- Only port 2 requests, 8 words of data 0x10..0x17, TX_DST_RDY=1 -> TX carries all 8 words in order on consecutive cycles with TX_PORT=2.
- All ports requesting and TX_DST_RDY held at 0 for 5 cycles -> the TX word is stable and RX_DST_RDY=0000 throughout. After release, the next TX_PORT is the next port in round-robin order.
- Port 1 sends a word with RX_VLD=0000 -> the word is accepted and not forwarded (TX_SRC_RDY=0 next cycle), and `last`=1.
- RESET asserted while out_full=1 -> TX_SRC_RDY=0 on the next cycle, and after RESET falls the first grant goes to port 0.
- With MVB_RR_ARB_BURST_EN, BURST_LEN=3, ports 0 and 1 requesting continuously -> TX_PORT sequence 0,0,0,1,1,1,0,…
